// File: rtl/riscv_core_cache_pkg.sv
// Shared core cache types: memory-port grant/state encoding and watchdog sizing.
package riscv_core_cache_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    GRANT_IC_RD = 2'b01,
    GRANT_DC_RD = 2'b10,
    GRANT_DC_WR = 2'b11
  } mem_grant_e;

  localparam int unsigned STRB_W    = 8;
  localparam int unsigned MIN_CNT_W = 16;

  // Wide enough to hold TIMEOUT-1 without wrapping, never narrower than 16 bits.
  function automatic int unsigned counter_width(input int unsigned limit);
    int unsigned w;
    w = int'($clog2(limit)) + 1;
    return (w > MIN_CNT_W) ? w : MIN_CNT_W;
  endfunction

endpackage

// File: rtl/riscv_core_rr_arbiter2.sv
// Two-requester round-robin pick (bit 0 = IC, bit 1 = DC) with a 1-bit fairness pointer.
module riscv_core_rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_served_dc,
  output logic [1:0] o_pick
);

  logic favour_dc_q, favour_dc_d;

  always_comb begin
    o_pick = '0;
    if (i_req[0] && (!i_req[1] || !favour_dc_q)) begin
      o_pick[0] = 1'b1;
    end else if (i_req[1]) begin
      o_pick[1] = 1'b1;
    end
  end

  // After serving one reader, favour the other.
  always_comb begin
    favour_dc_d = favour_dc_q;
    if (i_update) begin
      favour_dc_d = !i_served_dc;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      favour_dc_q <= 1'b0;
    end else begin
      favour_dc_q <= favour_dc_d;
    end
  end

endmodule

// File: rtl/riscv_core_mem_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and D-cache write-through onto one memory port,
// with captured request fields and a per-grant watchdog.
module riscv_core_mem_arbiter
  import riscv_core_cache_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned CORE_DATA_WIDTH = 64,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_ic_read_req,
  input  logic [ADDR_WIDTH-1:0]      i_ic_read_addr,
  output logic                       o_ic_read_done,
  input  logic                       i_dc_read_req,
  input  logic [ADDR_WIDTH-1:0]      i_dc_read_addr,
  output logic                       o_dc_read_done,
  input  logic                       i_dc_write_valid,
  input  logic [ADDR_WIDTH-1:0]      i_dc_write_addr,
  input  logic [CORE_DATA_WIDTH-1:0] i_dc_write_data,
  input  logic [STRB_W-1:0]          i_dc_write_strobe,
  output logic                       o_dc_write_done,
  output logic                       o_mem_read_req,
  output logic [ADDR_WIDTH-1:0]      o_mem_read_address,
  input  logic                       i_mem_read_done,
  output logic                       o_mem_write_valid,
  output logic [ADDR_WIDTH-1:0]      o_mem_write_address,
  output logic [CORE_DATA_WIDTH-1:0] o_mem_write_data,
  output logic [STRB_W-1:0]          o_mem_write_strobe,
  input  logic                       i_mem_write_done,
  output logic [1:0]                 o_grant,
  output logic                       o_timeout_err
);

  localparam int unsigned CNT_W = counter_width(TIMEOUT_CYCLES);

  mem_grant_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [CORE_DATA_WIDTH-1:0] data_q, data_d;
  logic [STRB_W-1:0]          strb_q, strb_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       err_q, err_d;
  logic                       dropped_q, dropped_d;

  logic [1:0] rd_pick;
  logic       rr_update;
  logic       owner_req;
  logic       mem_done;
  logic       timeout;
  logic       deliver;

  riscv_core_rr_arbiter2 u_rr (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       ({i_dc_read_req, i_ic_read_req}),
    .i_update    (rr_update),
    .i_served_dc (state_q == GRANT_DC_RD),
    .o_pick      (rd_pick)
  );

  always_comb begin
    owner_req = 1'b0;
    mem_done  = 1'b0;
    unique case (state_q)
      GRANT_IC_RD: begin owner_req = i_ic_read_req;    mem_done = i_mem_read_done;  end
      GRANT_DC_RD: begin owner_req = i_dc_read_req;    mem_done = i_mem_read_done;  end
      GRANT_DC_WR: begin owner_req = i_dc_write_valid; mem_done = i_mem_write_done; end
      default:     ;
    endcase
  end

  assign timeout = (state_q != IDLE) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  // A requester that let go at any point during its grant gets no completion pulse.
  assign deliver = mem_done && !timeout && owner_req && !dropped_q;

  assign o_grant             = state_q;
  assign o_timeout_err       = err_q;
  assign o_mem_read_req      = ((state_q == GRANT_IC_RD) || (state_q == GRANT_DC_RD)) && !i_mem_read_done;
  assign o_mem_write_valid   = (state_q == GRANT_DC_WR) && !i_mem_write_done;
  assign o_mem_read_address  = addr_q;
  assign o_mem_write_address = addr_q;
  assign o_mem_write_data    = data_q;
  assign o_mem_write_strobe  = strb_q;
  assign o_ic_read_done      = (state_q == GRANT_IC_RD) && deliver;
  assign o_dc_read_done      = (state_q == GRANT_DC_RD) && deliver;
  assign o_dc_write_done     = (state_q == GRANT_DC_WR) && deliver;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    strb_d    = strb_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    dropped_d = dropped_q;
    rr_update = 1'b0;
    if (state_q == IDLE) begin
      cnt_d     = '0;
      dropped_d = 1'b0;
      if (i_dc_write_valid) begin
        state_d = GRANT_DC_WR;
        addr_d  = i_dc_write_addr;
        data_d  = i_dc_write_data;
        strb_d  = i_dc_write_strobe;
      end else if (rd_pick[0]) begin
        state_d = GRANT_IC_RD;
        addr_d  = i_ic_read_addr;
      end else if (rd_pick[1]) begin
        state_d = GRANT_DC_RD;
        addr_d  = i_dc_read_addr;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!owner_req) begin
        dropped_d = 1'b1;
      end
      if (timeout) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else if (mem_done) begin
        state_d = IDLE;
      end
      rr_update = (state_d == IDLE) && (state_q != GRANT_DC_WR);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      dropped_q <= dropped_d;
    end
  end

endmodule

// File: tb/tb_riscv_core_mem_arbiter.sv
// Self-checking bench for riscv_core_mem_arbiter: transaction-order model plus directed corner cases.
module tb_riscv_core_mem_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned TO = 8;
  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_IC   = 2'b01;
  localparam logic [1:0] G_DC   = 2'b10;
  localparam logic [1:0] G_WR   = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          ic_req, dc_req, wr_valid;
  logic [AW-1:0] ic_addr, dc_addr, wr_addr;
  logic [DW-1:0] wr_data;
  logic [7:0]    wr_strb;
  logic          rd_done, wr_done;
  logic          ic_done_o, dc_done_o, wr_done_o;
  logic          rd_req_o, wr_valid_o;
  logic [AW-1:0] rd_addr_o, wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic [7:0]    wr_strb_o;
  logic [1:0]    grant_o;
  logic          err_o;

  int checks = 0;
  int errors = 0;
  bit rr_dc;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic [7:0]    exp_strb;

  always #5 clk = ~clk;

  riscv_core_mem_arbiter #(
    .ADDR_WIDTH      (AW),
    .CORE_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_ic_read_req       (ic_req),
    .i_ic_read_addr      (ic_addr),
    .o_ic_read_done      (ic_done_o),
    .i_dc_read_req       (dc_req),
    .i_dc_read_addr      (dc_addr),
    .o_dc_read_done      (dc_done_o),
    .i_dc_write_valid    (wr_valid),
    .i_dc_write_addr     (wr_addr),
    .i_dc_write_data     (wr_data),
    .i_dc_write_strobe   (wr_strb),
    .o_dc_write_done     (wr_done_o),
    .o_mem_read_req      (rd_req_o),
    .o_mem_read_address  (rd_addr_o),
    .i_mem_read_done     (rd_done),
    .o_mem_write_valid   (wr_valid_o),
    .o_mem_write_address (wr_addr_o),
    .o_mem_write_data    (wr_data_o),
    .o_mem_write_strobe  (wr_strb_o),
    .i_mem_write_done    (wr_done),
    .o_grant             (grant_o),
    .o_timeout_err       (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_grant"}, grant_o, G_NONE);
    chk({tag, "_rdreq"}, rd_req_o, 0);
    chk({tag, "_wrvalid"}, wr_valid_o, 0);
    chk({tag, "_icdone"}, ic_done_o, 0);
    chk({tag, "_dcdone"}, dc_done_o, 0);
    chk({tag, "_wrdone"}, wr_done_o, 0);
  endtask

  task automatic set_req(input logic [1:0] owner, input logic v);
    case (owner)
      G_IC:    ic_req = v;
      G_DC:    dc_req = v;
      default: wr_valid = v;
    endcase
  endtask

  // Entered at the negedge after the grant edge; returns at the following IDLE negedge (+1).
  task automatic serve(input logic [1:0] owner, input int lat, input bit drop,
                       input bit perturb, input logic [63:0] alt);
    bit is_wr;
    bit last;
    is_wr = (owner == G_WR);
    case (owner)
      G_IC: exp_addr = ic_addr;
      G_DC: exp_addr = dc_addr;
      default: begin exp_addr = wr_addr; exp_data = wr_data; exp_strb = wr_strb; end
    endcase
    for (int c = 0; c <= lat; c++) begin
      last = (c == lat);
      if (drop && c == 0) set_req(owner, 1'b0);
      if (perturb) begin
        case (owner)
          G_IC: ic_addr = alt;
          G_DC: dc_addr = alt;
          default: begin wr_addr = alt; wr_data = ~alt; wr_strb = 8'($urandom); end
        endcase
      end
      rd_done = is_wr ? 1'($urandom_range(0, 1)) : last;
      wr_done = is_wr ? last : 1'($urandom_range(0, 1));
      #1;
      chk("grant", grant_o, owner);
      chk("mem_rd_req", rd_req_o, !is_wr && !last);
      chk("mem_wr_valid", wr_valid_o, is_wr && !last);
      if (is_wr) begin
        chk("mem_wr_addr", wr_addr_o, exp_addr);
        chk("mem_wr_data", wr_data_o, exp_data);
        chk("mem_wr_strb", wr_strb_o, exp_strb);
      end else begin
        chk("mem_rd_addr", rd_addr_o, exp_addr);
      end
      chk("ic_done", ic_done_o, owner == G_IC && last && !drop);
      chk("dc_done", dc_done_o, owner == G_DC && last && !drop);
      chk("wr_done", wr_done_o, owner == G_WR && last && !drop);
      @(negedge clk);
    end
    rd_done = 1'b0;
    wr_done = 1'b0;
    set_req(owner, 1'b0);
    #1;
    chk_quiet("post_done");
  endtask

  // Raise a set of requests together and serve them in the order the arbitration rules dictate.
  task automatic batch(input bit ic, input bit dc, input bit wr, input bit allow_drop);
    bit p_ic, p_dc, p_wr;
    logic [1:0] owner;
    p_ic = ic; p_dc = dc; p_wr = wr;
    ic_req = ic; dc_req = dc; wr_valid = wr;
    rd_done = 1'($urandom_range(0, 1));
    wr_done = 1'($urandom_range(0, 1));
    #1;
    chk_quiet("arb_idle");
    while (p_ic || p_dc || p_wr) begin
      @(negedge clk);
      rd_done = 1'b0;
      wr_done = 1'b0;
      if (p_wr) owner = G_WR;
      else if (p_ic && (!p_dc || !rr_dc)) owner = G_IC;
      else owner = G_DC;
      serve(owner, $urandom_range(0, 4), allow_drop && ($urandom_range(0, 5) == 0),
            1'b1, {$urandom, $urandom});
      case (owner)
        G_IC: begin p_ic = 0; rr_dc = 1; end
        G_DC: begin p_dc = 0; rr_dc = 0; end
        default: p_wr = 0;
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "time limit");
  end

  initial begin
    bit a, b, w;
    rst = 1'b1;
    ic_req = 0; dc_req = 0; wr_valid = 0;
    ic_addr = '0; dc_addr = '0; wr_addr = '0; wr_data = '0; wr_strb = '0;
    rd_done = 0; wr_done = 0;
    rr_dc = 0;
    repeat (2) @(negedge clk);
    #1;
    chk_quiet("reset");
    chk("reset_err", err_o, 0);
    chk("reset_rdaddr", rd_addr_o, 0);
    chk("reset_wraddr", wr_addr_o, 0);
    chk("reset_wrdata", wr_data_o, 0);
    chk("reset_wrstrb", wr_strb_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // Simultaneous reads after reset: IC then DC.
    ic_addr = 64'h0000_0000_0000_4000;
    dc_addr = 64'h0000_0000_0000_5000;
    batch(1, 1, 0, 0);

    // Write beats a concurrent IC read.
    wr_addr = 64'h1008; wr_data = 64'hDEAD_BEEF_0123_4567; wr_strb = 8'h0F;
    ic_addr = 64'h6000;
    batch(1, 0, 1, 0);

    // Read address changed mid-grant stays captured.
    dc_addr = 64'h2000;
    dc_req = 1'b1;
    #1;
    chk("dc_arb_idle", grant_o, G_NONE);
    @(negedge clk);
    serve(G_DC, 3, 0, 1, 64'h3000);
    rr_dc = 0;

    // IC drops mid-grant: no done pulse, back to IDLE.
    ic_addr = 64'h7000;
    ic_req = 1'b1;
    #1;
    @(negedge clk);
    serve(G_IC, 3, 1, 0, 64'h0);
    rr_dc = 1;

    for (int it = 0; it < 40; it++) begin
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 2) == 0);
      if (!a && !b && !w) a = 1;
      ic_addr = {$urandom, $urandom};
      dc_addr = {$urandom, $urandom};
      wr_addr = {$urandom, $urandom};
      wr_data = {$urandom, $urandom};
      wr_strb = 8'($urandom);
      batch(a, b, w, 1);
    end

    // Watchdog: mem never answers; grant lasts TO cycles, then IDLE with sticky error.
    ic_req = 1'b1;
    ic_addr = 64'h8000;
    #1;
    @(negedge clk);
    for (int k = 0; k < int'(TO); k++) begin
      #1;
      chk("to_grant", grant_o, G_IC);
      chk("to_err_low", err_o, 0);
      chk("to_icdone", ic_done_o, 0);
      @(negedge clk);
    end
    ic_req = 1'b0;
    #1;
    chk_quiet("to_idle");
    chk("to_err_set", err_o, 1);
    repeat (2) @(negedge clk);
    #1;
    chk("to_err_sticky", err_o, 1);

    // Reset in the middle of a write grant.
    wr_addr = 64'h9008; wr_data = 64'h1111_2222_3333_4444; wr_strb = 8'hF0;
    wr_valid = 1'b1;
    #1;
    @(negedge clk);
    #1;
    chk("rstwr_grant", grant_o, G_WR);
    chk("rstwr_valid", wr_valid_o, 1);
    @(negedge clk);
    rst = 1'b1;
    wr_done = 1'b1;
    #1;
    chk_quiet("rstwr");
    chk("rstwr_err", err_o, 0);
    chk("rstwr_addr", wr_addr_o, 0);
    chk("rstwr_data", wr_data_o, 0);
    chk("rstwr_strb", wr_strb_o, 0);
    @(negedge clk);
    #1;
    chk("rstwr_done_held", wr_done_o, 0);
    wr_done = 1'b0;
    wr_valid = 1'b0;
    rst = 1'b0;
    rr_dc = 0;

    // Pointer back to IC after reset.
    ic_addr = 64'hA000;
    dc_addr = 64'hB000;
    batch(1, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_core_mem_arbiter.md
RISCV_CORE_MEM_ARBITER -- requirements
Module: riscv_core_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, the address width of every port.
REQ-002 SHALL have parameter CORE_DATA_WIDTH, default 64, the write data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, the watchdog limit per granted transaction.
REQ-004 SHALL use one clock and an asynchronous, active-high reset: i_clk  in  1  rising-edge clock.
REQ-005 SHALL have i_rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have i_ic_read_req  in  1 (I-cache line-fill request) and i_ic_read_addr  in  ADDR_WIDTH (line address).
REQ-007 SHALL have o_ic_read_done  out  1  line-fill complete pulse to the I-cache.
REQ-008 SHALL have i_dc_read_req  in  1 and i_dc_read_addr  in  ADDR_WIDTH (D-cache line-fill request and address).
REQ-009 SHALL have o_dc_read_done  out  1  line-fill complete pulse to the D-cache.
REQ-010 SHALL have i_dc_write_valid  in  1, i_dc_write_addr  in  ADDR_WIDTH, i_dc_write_data  in  CORE_DATA_WIDTH and i_dc_write_strobe  in  8 (D-cache write-through request).
REQ-011 SHALL have o_dc_write_done  out  1  write-through complete pulse.
REQ-012 SHALL have o_mem_read_req  out  1, o_mem_read_address  out  ADDR_WIDTH and i_mem_read_done  in  1 (AXI read channel side).
REQ-013 SHALL have o_mem_write_valid  out  1, o_mem_write_address  out  ADDR_WIDTH, o_mem_write_data  out  CORE_DATA_WIDTH, o_mem_write_strobe  out  8 and i_mem_write_done  in  1 (AXI write channel side).
REQ-014 SHALL have o_grant  out  2, the current owner: 00 none, 01 IC read, 10 DC read, 11 DC write.
REQ-015 SHALL have o_timeout_err  out  1, a sticky watchdog error flag.

Function
REQ-016 SHALL implement the FSM states IDLE, GRANT_IC_RD, GRANT_DC_RD and GRANT_DC_WR.
REQ-017 In IDLE, SHALL select at most one pending request per cycle and enter the matching grant state on the next edge; the minimum arbitration latency is 1 cycle.
REQ-018 Priority: DC write beats both reads; between the two reads, a 1-bit round-robin pointer decides.
REQ-019 The pointer SHALL favour the read requester not served last; after reset it favours IC.
REQ-020 The pointer SHALL update only when a read grant completes.
REQ-021 On grant, the address, data and strobe SHALL be captured into registers; the mem-side outputs SHALL drive the registered values for the whole grant, independent of later input changes.
REQ-022 In a read grant, o_mem_read_req SHALL be 1 until the cycle i_mem_read_done=1, and SHALL be 0 in that cycle.
REQ-023 In GRANT_DC_WR, o_mem_write_valid SHALL follow the same rule using i_mem_write_done.
REQ-024 The done pulse to the owner SHALL be combinational from the mem done in that same cycle, last exactly 1 cycle, and be followed by IDLE on the next edge.
REQ-025 Done inputs arriving for a non-granted channel, or while in IDLE, SHALL be ignored.
REQ-026 If the owner drops its request mid-grant, the grant SHALL still run to the mem done; the done pulse SHALL then be suppressed.
REQ-027 A 16-bit-or-wider cycle counter SHALL clear on grant entry and increment each granted cycle.
REQ-028 When the counter reaches TIMEOUT_CYCLES-1, the block SHALL set o_timeout_err, return to IDLE and issue no done pulse.
REQ-029 o_grant SHALL be a registered encoding of the FSM state.
REQ-030 Requests held continuously SHALL each be served within 2 grants after any pending write.

Reset
REQ-031 While i_rst=1: state IDLE, all outputs 0, capture registers 0, RR pointer favours IC, counter 0, o_timeout_err 0.
REQ-032 Reset mid-grant SHALL abandon the transaction with no done pulse; the AXI channels are reset by the same i_rst.

Structure
REQ-033 The grant/state encoding enum SHALL live in the shared core cache package, riscv_core_cache_pkg.
REQ-034 One sub-module, riscv_core_rr_arbiter2, SHALL hold the 2-requester round-robin pick and pointer.
REQ-035 The FSM, capture registers and watchdog SHALL live in the top module.

Verification
REQ-036 IC and DC read requests both raised at the same time after reset -> IC granted first (o_grant=01), DC granted on the next IDLE (10).
REQ-037 DC write (addr 0x1008, strobe 0x0F) raised together with an IC read -> write granted first; the mem side sees 0x1008/0x0F; o_dc_write_done pulses for 1 cycle.
REQ-038 Change i_dc_read_addr from 0x2000 to 0x3000 mid-grant -> o_mem_read_address stays 0x2000 until done.
REQ-039 TIMEOUT_CYCLES=8 with i_mem_read_done held 0 -> o_timeout_err=1 at cycle 8 of the grant, FSM returns to IDLE, no done pulse.
REQ-040 Assert i_rst during GRANT_DC_WR -> all outputs 0 immediately, no o_dc_write_done.
REQ-041 IC drops its request mid-grant, then mem done arrives -> o_ic_read_done stays 0 and the FSM returns to IDLE.
